// File: rtl/uart_pkg.sv
// Shared UART definitions: parity-mode constants and the receiver state encoding.
`timescale 1ns/1ps
package uart_pkg;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_ODD  = 1;
    localparam int unsigned PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StDone
    } rx_state_e;

endpackage

// File: rtl/uart_bit_sampler.sv
// Two-flop synchronizer for the serial line plus a 3-sample majority vote over
// the synchronized value (current sample and the two before it).
`timescale 1ns/1ps
module uart_bit_sampler (
    input  logic CLOCK,
    input  logic RESET,
    input  logic rx_serial_i,
    output logic rxs_o,
    output logic vote_o
);

    logic sync1_q, sync2_q;
    logic hist1_q, hist2_q;

    // Everything resets to the idle-line level so no spurious low is seen.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            hist1_q <= 1'b1;
            hist2_q <= 1'b1;
        end else begin
            sync1_q <= rx_serial_i;
            sync2_q <= sync1_q;
            hist1_q <= sync2_q;
            hist2_q <= hist1_q;
        end
    end

    assign rxs_o  = sync2_q;
    assign vote_o = (hist2_q & hist1_q) | (hist2_q & sync2_q) | (hist1_q & sync2_q);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: start/data/parity/stop sequencing with midpoint
// majority sampling, error flags and break protection.
`timescale 1ns/1ps
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned CLK       = 16,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    input  logic                 RX_SERIAL,
    output logic                 RX_VALID,
    output logic [DATA_BITS-1:0] RX_PARALLEL,
    output logic                 PARITY_ERR,
    output logic                 FRAME_ERR,
    output logic                 BUSY
);

    localparam int unsigned CntW = $clog2(CLK);
    localparam int unsigned BitW = $clog2(DATA_BITS);
    localparam logic [CntW-1:0] HalfLast = CntW'(CLK / 2 - 1);
    localparam logic [CntW-1:0] FullLast = CntW'(CLK - 1);
    localparam logic [BitW-1:0] DataLast = BitW'(DATA_BITS - 1);
    localparam logic [BitW-1:0] StopLast = BitW'(STOP_BITS - 1);

    rx_state_e            state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [BitW-1:0]      bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 fbad_q, fbad_d;
    logic                 armed_q, armed_d;
    logic [DATA_BITS-1:0] data_q;
    logic                 perr_q, ferr_q;
    logic                 load;
    logic                 rxs, vote, perr_calc;

    uart_bit_sampler u_sampler (
        .CLOCK       (CLOCK),
        .RESET       (RESET),
        .rx_serial_i (RX_SERIAL),
        .rxs_o       (rxs),
        .vote_o      (vote)
    );

    // par_q is the XOR of all data bits and the received parity bit.
    assign perr_calc = (PARITY == PARITY_ODD)  ? ~par_q :
                       (PARITY == PARITY_EVEN) ?  par_q : 1'b0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        fbad_d  = fbad_q;
        armed_d = armed_q | rxs;
        load    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (armed_q && !rxs) begin
                    state_d = StStart;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            StStart: begin
                if (cnt_q == HalfLast) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    par_d   = 1'b0;
                    fbad_d  = 1'b0;
                    state_d = vote ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (cnt_q == FullLast) begin
                    cnt_d   = '0;
                    shift_d = {vote, shift_q[DATA_BITS-1:1]};
                    par_d   = par_q ^ vote;
                    if (bit_q == DataLast) begin
                        bit_d   = '0;
                        state_d = (PARITY != PARITY_NONE) ? StParity : StStop;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StParity: begin
                if (cnt_q == FullLast) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    par_d   = par_q ^ vote;
                    state_d = StStop;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (cnt_q == FullLast) begin
                    cnt_d  = '0;
                    fbad_d = fbad_q | ~vote;
                    if (bit_q == StopLast) begin
                        bit_d   = '0;
                        load    = 1'b1;
                        state_d = StDone;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
                // A framing error with the line still low looks like a break; wait for high.
                if (ferr_q && !rxs) begin
                    armed_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            fbad_q  <= 1'b0;
            armed_q <= 1'b0;
            data_q  <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            fbad_q  <= fbad_d;
            armed_q <= armed_d;
            if (load) begin
                data_q <= shift_q;
                perr_q <= perr_calc;
                ferr_q <= fbad_d;
            end
        end
    end

    assign RX_VALID    = (state_q == StDone);
    assign BUSY        = (state_q != StIdle);
    assign RX_PARALLEL = data_q;
    assign PARITY_ERR  = perr_q;
    assign FRAME_ERR   = ferr_q;

endmodule
